// File: rtl/vreg_file_multi_if.sv
// Bus bundle for the vector register file: clear control, two read ports, one lane-masked write port.
// The master side drives requests and the slave side (the register file) returns ready and read data.
interface vreg_file_multi_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                   clear;
    logic                   ready;
    logic                   rd_en1;
    logic [AW-1:0]          rd_addr1;
    logic [LANES*WIDTH-1:0] rd_data1;
    logic                   rd_valid1;
    logic                   rd_en2;
    logic [AW-1:0]          rd_addr2;
    logic [LANES*WIDTH-1:0] rd_data2;
    logic                   rd_valid2;
    logic [LANES-1:0]       wr_lane_en;
    logic [AW-1:0]          wr_addr;
    logic [LANES*WIDTH-1:0] wr_data;
    logic                   wr_splat;

    modport master (
        output clear, rd_en1, rd_addr1, rd_en2, rd_addr2,
               wr_lane_en, wr_addr, wr_data, wr_splat,
        input  ready, rd_data1, rd_valid1, rd_data2, rd_valid2
    );

    modport slave (
        input  clear, rd_en1, rd_addr1, rd_en2, rd_addr2,
               wr_lane_en, wr_addr, wr_data, wr_splat,
        output ready, rd_data1, rd_valid1, rd_data2, rd_valid2
    );
endinterface

// File: rtl/vreg_file_multi.sv
// Vector register file, 2 registered read ports (1-cycle latency, write bypass) and 1 lane-masked write port.
// No backpressure; ready is low while the clear sequencer zeroes storage, and requests then are dropped.
module vreg_file_multi #(
    parameter int LANES = 4,
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input logic            clk,
    input logic            rst_n,
    vreg_file_multi_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = LANES * WIDTH;

    typedef enum logic {CLR, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             rd_valid1_q, rd_valid1_d, rd_valid2_q, rd_valid2_d;
    logic [DW-1:0]    rd_data1_q, rd_data1_d, rd_data2_q, rd_data2_d;
    logic [DW-1:0]    mem [DEPTH];

    logic             run, wr_act, clr_act;
    logic [DW-1:0]    wr_val;
    logic [LANES-1:0] mask1, mask2;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [LANES-1:0] sel);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < LANES; i++)
            if (sel[i]) r[i*WIDTH +: WIDTH] = new_w[i*WIDTH +: WIDTH];
        return r;
    endfunction

    always_comb begin
        // clear takes priority over any same-cycle access
        run     = (state_q == RUN) && !bus.clear;
        clr_act = (state_q == CLR) && !bus.clear;
        wr_val  = '0;
        for (int i = 0; i < LANES; i++)
            wr_val[i*WIDTH +: WIDTH] = bus.wr_splat ? bus.wr_data[WIDTH-1:0] : bus.wr_data[i*WIDTH +: WIDTH];
        wr_act = run && (|bus.wr_lane_en) && in_range(bus.wr_addr);
        mask1  = (wr_act && (bus.rd_addr1 == bus.wr_addr)) ? bus.wr_lane_en : '0;
        mask2  = (wr_act && (bus.rd_addr2 == bus.wr_addr)) ? bus.wr_lane_en : '0;

        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.clear) begin
            state_d = CLR;
            cnt_d   = '0;
        end else if (state_q == CLR) begin
            if (cnt_q == CW'(DEPTH - 1)) state_d = RUN;
            else                         cnt_d   = cnt_q + CW'(1);
        end
        ready_d = (state_d == RUN);

        rd_valid1_d = run && bus.rd_en1;
        rd_valid2_d = run && bus.rd_en2;
        rd_data1_d  = rd_data1_q;
        rd_data2_d  = rd_data2_q;
        if (rd_valid1_d)
            rd_data1_d = in_range(bus.rd_addr1) ? merge(mem[bus.rd_addr1], wr_val, mask1) : '0;
        if (rd_valid2_d)
            rd_data2_d = in_range(bus.rd_addr2) ? merge(mem[bus.rd_addr2], wr_val, mask2) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLR;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            rd_valid1_q <= 1'b0;
            rd_valid2_q <= 1'b0;
            rd_data1_q  <= '0;
            rd_data2_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            rd_valid1_q <= rd_valid1_d;
            rd_valid2_q <= rd_valid2_d;
            rd_data1_q  <= rd_data1_d;
            rd_data2_q  <= rd_data2_d;
        end
    end

    // Storage has no reset so it can map onto RAM; the clear sequencer initialises it.
    always_ff @(posedge clk) begin
        if (clr_act) begin
            mem[cnt_q[AW-1:0]] <= '0;
        end else if (wr_act) begin
            for (int i = 0; i < LANES; i++)
                if (bus.wr_lane_en[i])
                    mem[bus.wr_addr][i*WIDTH +: WIDTH] <= wr_val[i*WIDTH +: WIDTH];
        end
    end

    assign bus.ready     = ready_q;
    assign bus.rd_valid1 = rd_valid1_q;
    assign bus.rd_valid2 = rd_valid2_q;
    assign bus.rd_data1  = rd_data1_q;
    assign bus.rd_data2  = rd_data2_q;
endmodule

// File: doc/vreg_file_multi.md
# vreg_file_multi

Parametrised vector register file for the vector datapath. It provides two read ports with registered outputs and a write port with per-lane enables, lane-0 splat, and same-cycle write-to-read bypass. A built-in clear sequencer zeroes every entry after reset or on request, so the storage array needs no reset and maps onto inferred RAM. It replaces the fixed 4-lane × 32-bit file that had unregistered reads.

## Interface
- LANES, 4, vector lanes per register
- WIDTH, 32, bits per lane
- DEPTH, 32, number of vector registers; need not be a power of two
- AW, $clog2(DEPTH), address width; derived localparam, not overridable

- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  pulse; starts (or restarts) the zeroing sequence
- ready  out  1  high when the file accepts reads and writes
- rd_en1  in  1  read request, port 1
- rd_addr1  in  AW  read address, port 1
- rd_data1  out  LANES*WIDTH  port 1 data; lane i is bits [i*WIDTH +: WIDTH]
- rd_valid1  out  1  rd_data1 holds a fresh read result
- rd_en2, rd_addr2, rd_data2, rd_valid2  same as port 1, for port 2
- wr_lane_en  in  LANES  per-lane write enable; any bit set means a write this cycle
- wr_addr  in  AW  write address
- wr_data  in  LANES*WIDTH  write data
- wr_splat  in  1  when 1, every enabled lane takes wr_data lane 0

## Operation
- **States.** The block has two states, CLR and RUN.
  - Reset enters CLR with counter cnt = 0.
  - In CLR, each cycle writes zero to all lanes of entry cnt, then increments cnt.
  - After cnt = DEPTH-1 is written, the block enters RUN.
- **clear input.**
  - clear = 1 in RUN goes to CLR with cnt = 0.
  - clear = 1 in CLR restarts cnt at 0.
- **While in CLR:**
  - ready = 0.
  - Writes are dropped.
  - rd_valid1/2 = 0 and rd_data1/2 hold their values.
- **Writes (RUN only).** For each lane i with wr_lane_en[i] = 1, entry[wr_addr] lane i takes the new value:
  - wr_data lane 0 when wr_splat = 1;
  - wr_data lane i otherwise.
  - Disabled lanes keep their contents.
- **Reads (RUN only).** With rd_enN = 1, rd_dataN registers entry[rd_addrN] and rd_validN = 1 on the next cycle.
  - With rd_enN = 0, rd_validN = 0 and rd_dataN holds.
- **Bypass.**
  - If a read and a write in the same cycle share an address, enabled lanes return the new (post-splat) write value.
  - Disabled lanes return the old contents.
  - Both ports bypass independently; both may read the write address together.
- **Out-of-range addresses** (addr ≥ DEPTH, only possible when DEPTH is not a power of two):
  - Writes are dropped.
  - Reads return all zeros with rd_valid = 1.
- **Storage** is not reset by rst_n; only the CLR sequence initialises it.

## Timing
- **Reset values (async, while rst_n = 0):**
  - state = CLR, cnt = 0, ready = 0;
  - rd_valid1/2 = 0, rd_data1/2 = 0.
- **Clear duration.** The first posedge after rst_n rises clears entry 0. ready is registered and rises at the DEPTH-th posedge, so reads and writes are accepted from the next edge on.
- **Read latency.** A read sampled at edge N presents its data and valid after edge N, i.e. one cycle of latency. Back-to-back reads every cycle are supported on each port.
- **Write visibility.**
  - A write at edge N is visible to a read sampled at edge N through the bypass.
  - It is visible from storage for reads at edge N+1 and later.
- **clear in the same cycle as a write or read in RUN.** clear wins: the write is dropped, rd_valid = 0 next cycle, and ready falls after that edge.
- **rst_n asserted mid-clear or mid-read.** All outputs return to the reset values immediately, and the clear restarts from entry 0 after release.
- **cnt** is ceil(log2(DEPTH+1)) bits wide and does not wrap within one sequence.

## Test plan
- **Reset and clear.** Default params: release rst_n, wait 32 edges → ready = 0 through edge 31 and ready = 1 after edge 32. Then read r0..r31 on both ports → every lane 0, with rd_valid = 1 one cycle after each request.
- **Per-lane write.** Write r5 with lanes {0x11,0x22,0x33,0x44}, then write r5 with lane_en = 4'b0100 and lane 2 = 0xAA. Read r5 → {0x11,0x22,0xAA,0x44}.
- **Bypass and splat.** In one cycle, write r7 with wr_splat = 1, lane_en = 4'b1011, lane 0 = 0xDEAD, while both ports read r7 and r7 previously held all 0x5. Both ports return lanes 0, 1, 3 = 0xDEAD and lane 2 = 0x5.
- **Clear mid-operation.** After filling r0..r31 with nonzero data, pulse clear in the same cycle as a write to r3. ready = 0 for 32 cycles, the write is dropped, and all entries read 0 afterwards.
- **Non-power-of-two depth.** With DEPTH = 24, write r25 then read r25 → zeros with rd_valid = 1; r0..r23 are unaffected. Clear completes in 24 cycles.
- **Reset during clear.** Assert rst_n low at clear cycle 10 → ready = 0 and rd_valid = 0 immediately. After release, a full 32-cycle clear runs again.
